peri_reg_hub: RTL and testbench
===============================

PERI_REG_HUB -- requirements
Module: peri_reg_hub

Interface
REQ-001 Parameter NS, default 4, number of slave channels (1..16).
REQ-002 Parameter AW, default 11, host register address width.
REQ-003 Parameter SW, default 4, select field width, taken from reg_addr[AW-1:AW-SW].
REQ-004 Parameter TO_CYC, default 255, access timeout in mclk cycles (1..65535).
REQ-005 The block SHALL have one clock, mclk, and an asynchronous, active-high reset, s_reset.
REQ-006 mclk  in  1  system clock; all logic is clocked on its rising edge.
REQ-007 s_reset  in  1  asynchronous active-high reset.
REQ-008 reg_cs/reg_wr  in  1/1  host request and write qualifier, held high until reg_ack.
REQ-009 reg_addr/reg_wdata/reg_be  in  AW/32/4  host address, write data and byte enables.
REQ-010 reg_rdata/reg_ack/reg_err  out  32/1/1  response data, one-cycle ack and error flag.
REQ-011 slv_cs  out  NS  one-hot slave select.
REQ-012 slv_wr/slv_addr/slv_wdata/slv_be  out  1/AW-SW/32/4  registered request fields shared by all slaves.
REQ-013 slv_rdata/slv_ack  in  NS*32/NS  per-slave read data and ack; channel i occupies slv_rdata[32*i+31:32*i].
REQ-014 err_clr  in  1  synchronous clear of the error status.
REQ-015 err_cnt/err_sel  out  8/SW  saturating error count and select value of the most recent error.

Function
REQ-016 The FSM SHALL use four states: IDLE, ACCESS, RESP and GAP.
REQ-017 IDLE: with reg_cs=1, latch wr/addr/wdata/be and sel=reg_addr[AW-1:AW-SW]; go to ACCESS if sel<NS, else go to RESP with error.
REQ-018 ACCESS: assert slv_cs[sel] only; increment the timeout counter from 0 each cycle.
REQ-019 ACCESS: slv_ack[sel]=1 captures slv_rdata[sel] and moves to RESP with reg_err=0.
REQ-020 ACCESS: the counter reaching TO_CYC-1 without ack moves to RESP with rdata 32'hDEAD_0000|sel and reg_err=1.
REQ-021 If ack and timeout occur in the same cycle, the ack SHALL win.
REQ-022 slv_ack from non-selected channels, or outside ACCESS, SHALL be ignored.
REQ-023 RESP: reg_ack=1 for exactly one cycle with registered reg_rdata/reg_err; slv_cs=0; next state GAP.
REQ-024 GAP: reg_cs SHALL be ignored for one cycle, then the FSM returns to IDLE.
REQ-025 A reg_cs sampled in IDLE at cycle T with a combinational slave ack SHALL give reg_ack at T+2; the minimum request-to-request period is 4 cycles.
REQ-026 For an unmapped select (sel>=NS), reg_ack SHALL occur at T+1 with reg_rdata=0 and reg_err=1, and no slv_cs asserted.
REQ-027 On each error, err_cnt SHALL increment, saturating at 255, and err_sel SHALL be loaded with sel.
REQ-028 err_clr SHALL zero err_cnt and err_sel; if it coincides with an error, the clear wins.
REQ-029 reg_rdata SHALL be 0 in every cycle where reg_ack=0.

Reset
REQ-030 On s_reset the FSM SHALL enter IDLE, including mid-access, and the following outputs SHALL be 0: slv_cs, reg_ack, reg_err, reg_rdata, slv_wr, slv_addr, slv_wdata, slv_be, err_cnt, err_sel; the timeout counter SHALL also clear.
REQ-031 An access interrupted by reset SHALL NOT produce reg_ack after reset release.

Structure
REQ-032 Package peri_hub_pkg SHALL hold the FSM state enum and the DEAD_CODE constant (16'hDEAD).
REQ-033 The timeout counter SHALL be a sub-module, peri_hub_timer (start, clear, expire, parameter TO_CYC).
REQ-034 Decode, mux and FSM SHALL reside in peri_reg_hub; no clock-skew or reset-sync logic inside.

Verification
REQ-035 Read ch2 (addr 11'h100) with slave acking 3 cycles after slv_cs, rdata 32'h1234_5678 -> reg_ack once, reg_rdata 32'h1234_5678, reg_err 0, slv_cs 4'b0100.
REQ-036 Write ch0 with wdata 32'hA5A5_A5A5 and be 4'b0011 -> slv_wr/slv_wdata/slv_be match, reg_ack at T+2 with a combinational ack.
REQ-037 Access sel=5 with NS=4 -> reg_ack at T+1, reg_rdata 0, reg_err 1, err_cnt 1, err_sel 5.
REQ-038 Silent ch1 with TO_CYC=16 -> reg_ack after 16 ACCESS cycles, rdata 32'hDEAD_0001, reg_err 1.
REQ-039 Ack and timeout in the same cycle -> slave data returned, reg_err 0; 300 errors -> err_cnt 255; err_clr -> 0.
REQ-040 s_reset pulsed mid-ACCESS -> slv_cs 0 immediately, no reg_ack afterwards, and the next access completes normally.

Source files
------------

// File: rtl/peri_hub_pkg.sv
// -----------------------------------------------------------------------------
// peri_hub_pkg
// Shared definitions for the peripheral register hub:
//   hub_state_e  - request FSM states (IDLE, ACCESS, RESP, GAP)
//   DEAD_CODE    - upper half of the read data returned on an access timeout
//   ERR_CNT_MAX  - saturation value of the error counter
// -----------------------------------------------------------------------------
package peri_hub_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        GAP    = 2'd3
    } hub_state_e;

    localparam logic [15:0] DEAD_CODE   = 16'hDEAD;
    localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/peri_hub_timer.sv
// -----------------------------------------------------------------------------
// peri_hub_timer
// Access timeout counter. Counts mclk cycles while start is high, beginning
// at 0 in the first counted cycle; expire is raised combinationally in the
// cycle where the count has reached TO_CYC-1, i.e. in the TO_CYC-th cycle.
// Ports:
//   mclk    in  system clock
//   s_reset in  asynchronous active-high reset
//   start   in  count enable (high for every cycle of an access)
//   clear   in  return count to zero (has priority over start)
//   expire  out timeout reached in this cycle
// -----------------------------------------------------------------------------
module peri_hub_timer #(
    parameter int TO_CYC = 255
) (
    input  logic mclk,
    input  logic s_reset,
    input  logic start,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = start && !clear && (cnt_q == LAST);

endmodule

// File: rtl/peri_reg_hub.sv
// -----------------------------------------------------------------------------
// peri_reg_hub
// Bridges a single host register port onto NS slave channels. The top SW
// address bits select the channel; the rest is forwarded as slv_addr.
// Unmapped selects and slave timeouts are answered with reg_err and counted.
// Ports:
//   mclk, s_reset                  clock, asynchronous active-high reset
//   reg_cs, reg_wr                 host request / write (held until reg_ack)
//   reg_addr, reg_wdata, reg_be    host address, write data, byte enables
//   reg_rdata, reg_ack, reg_err    one-cycle response (rdata is 0 otherwise)
//   slv_cs                         one-hot channel select (ACCESS only)
//   slv_wr, slv_addr, slv_wdata,
//   slv_be                         registered request fields, shared
//   slv_rdata, slv_ack             per-channel read data (32 bits each), ack
//   err_clr                        synchronous clear of error status
//   err_cnt, err_sel               saturating error count, last error select
// -----------------------------------------------------------------------------
module peri_reg_hub #(
    parameter int NS     = 4,
    parameter int AW     = 11,
    parameter int SW     = 4,
    parameter int TO_CYC = 255
) (
    input  logic                 mclk,
    input  logic                 s_reset,
    input  logic                 reg_cs,
    input  logic                 reg_wr,
    input  logic [AW-1:0]        reg_addr,
    input  logic [31:0]          reg_wdata,
    input  logic [3:0]           reg_be,
    output logic [31:0]          reg_rdata,
    output logic                 reg_ack,
    output logic                 reg_err,
    output logic [NS-1:0]        slv_cs,
    output logic                 slv_wr,
    output logic [AW-SW-1:0]     slv_addr,
    output logic [31:0]          slv_wdata,
    output logic [3:0]           slv_be,
    input  logic [NS*32-1:0]     slv_rdata,
    input  logic [NS-1:0]        slv_ack,
    input  logic                 err_clr,
    output logic [7:0]           err_cnt,
    output logic [SW-1:0]        err_sel
);

    import peri_hub_pkg::*;

    // One extra bit so NS=2**SW still compares correctly.
    localparam logic [SW:0] NS_W = (SW + 1)'(NS);

    hub_state_e        state_q, state_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [NS-1:0]     slv_cs_q, slv_cs_d;
    logic              wr_q, wr_d;
    logic [AW-SW-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [SW-1:0]     err_sel_q, err_sel_d;

    logic [SW-1:0]     sel_in;
    logic              sel_mapped;
    logic              err_event;
    logic [SW-1:0]     err_event_sel;
    logic              timer_expire;
    logic              in_access;

    // Per-channel read data split out of the flat bus.
    logic [31:0]       ch_rdata [NS];
    logic [31:0]       mux_rdata;
    logic              ack_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_ch
            assign ch_rdata[gi] = slv_rdata[32*gi +: 32];
        end
    endgenerate

    assign sel_in     = reg_addr[AW-1 -: SW];
    assign sel_mapped = ({1'b0, sel_in} < NS_W);
    assign in_access  = (state_q == ACCESS);

    // slv_cs_q is one-hot only during ACCESS, so masking with it both picks
    // the selected channel and discards acks from every other channel.
    always_comb begin
        mux_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            if (slv_cs_q[i]) begin
                mux_rdata = mux_rdata | ch_rdata[i];
            end
        end
    end

    assign ack_hit = in_access && (|(slv_ack & slv_cs_q));

    peri_hub_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .mclk    (mclk),
        .s_reset (s_reset),
        .start   (in_access),
        .clear   (!in_access),
        .expire  (timer_expire)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        slv_cs_d      = slv_cs_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        rdata_d       = '0;
        err_cnt_d     = err_cnt_q;
        err_sel_d     = err_sel_q;
        err_event     = 1'b0;
        err_event_sel = sel_q;

        unique case (state_q)
            IDLE: begin
                if (reg_cs) begin
                    sel_d   = sel_in;
                    wr_d    = reg_wr;
                    addr_d  = reg_addr[AW-SW-1:0];
                    wdata_d = reg_wdata;
                    be_d    = reg_be;
                    if (sel_mapped) begin
                        slv_cs_d = NS'(1) << sel_in;
                        state_d  = ACCESS;
                    end else begin
                        // Answer directly; no slave is touched.
                        ack_d         = 1'b1;
                        err_d         = 1'b1;
                        err_event     = 1'b1;
                        err_event_sel = sel_in;
                        state_d       = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (ack_hit) begin
                    ack_d    = 1'b1;
                    rdata_d  = mux_rdata;
                    slv_cs_d = '0;
                    state_d  = RESP;
                end else if (timer_expire) begin
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = {DEAD_CODE, 16'(sel_q)};
                    err_event = 1'b1;
                    slv_cs_d  = '0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                slv_cs_d = '0;
            end
        endcase

        if (err_event) begin
            err_sel_d = err_event_sel;
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        if (err_clr) begin
            err_cnt_d = '0;
            err_sel_d = '0;
        end
    end

    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            slv_cs_q  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
            err_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            slv_cs_q  <= slv_cs_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign reg_ack   = ack_q;
    assign reg_err   = err_q;
    assign reg_rdata = rdata_q;
    assign slv_cs    = slv_cs_q;
    assign slv_wr    = wr_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign slv_be    = be_q;
    assign err_cnt   = err_cnt_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_peri_reg_hub.sv
// -----------------------------------------------------------------------------
// tb_peri_reg_hub
// Self-checking bench for peri_reg_hub with NS=4, AW=11, SW=4, TO_CYC=16.
// Slaves are modelled as "ack d cycles after slv_cs rises" (d<0 = silent),
// optionally with stray acks on unselected channels.
// -----------------------------------------------------------------------------
module tb_peri_reg_hub;

    localparam int NS = 4;
    localparam int AW = 11;
    localparam int SW = 4;
    localparam int TO = 16;

    logic              mclk = 1'b0;
    logic              s_reset = 1'b1;
    logic              reg_cs = 1'b0;
    logic              reg_wr = 1'b0;
    logic [AW-1:0]     reg_addr = '0;
    logic [31:0]       reg_wdata = '0;
    logic [3:0]        reg_be = '0;
    logic [31:0]       reg_rdata;
    logic              reg_ack;
    logic              reg_err;
    logic [NS-1:0]     slv_cs;
    logic              slv_wr;
    logic [AW-SW-1:0]  slv_addr;
    logic [31:0]       slv_wdata;
    logic [3:0]        slv_be;
    logic [NS*32-1:0]  slv_rdata;
    logic [NS-1:0]     slv_ack;
    logic              err_clr = 1'b0;
    logic [7:0]        err_cnt;
    logic [SW-1:0]     err_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model state
    int            ack_delay [NS];
    logic [31:0]   slv_mem   [NS];
    int            cs_cnt    [NS];
    logic          noise_en = 1'b0;
    logic [NS-1:0] spur = '0;

    // Expected error status
    int exp_cnt = 0;
    int exp_sel = 0;

    typedef struct {
        int            lat;
        int            acks;
        logic [31:0]   rdata;
        logic          err;
        logic [NS-1:0] cs_or;
        logic          f_wr;
        logic [AW-SW-1:0] f_addr;
        logic [31:0]   f_wdata;
        logic [3:0]    f_be;
        logic          leak;
    } obs_t;

    peri_reg_hub #(
        .NS(NS), .AW(AW), .SW(SW), .TO_CYC(TO)
    ) dut (
        .mclk(mclk), .s_reset(s_reset),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err),
        .slv_cs(slv_cs), .slv_wr(slv_wr), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_be(slv_be),
        .slv_rdata(slv_rdata), .slv_ack(slv_ack),
        .err_clr(err_clr), .err_cnt(err_cnt), .err_sel(err_sel)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) begin
        for (int i = 0; i < NS; i++) cs_cnt[i] <= slv_cs[i] ? cs_cnt[i] + 1 : 0;
    end

    always @(negedge mclk) begin
        spur = noise_en ? NS'($urandom) : '0;
    end

    always_comb begin
        slv_ack   = '0;
        slv_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            slv_ack[i] = (slv_cs[i] && ack_delay[i] >= 0 && cs_cnt[i] >= ack_delay[i])
                         || (spur[i] && !slv_cs[i]);
            slv_rdata[32*i +: 32] = slv_mem[i];
        end
    end

    // Reference: response rules expressed directly as latency/data/error,
    // plus the saturating error status.
    function automatic void model(input int sel, input int d, output int lat,
                                  output logic [31:0] data, output logic err);
        if (sel >= NS) begin
            lat = 1; data = 32'h0; err = 1'b1;
        end else if (d < 0 || d >= TO) begin
            lat = TO + 1; data = {16'hDEAD, 16'(sel)}; err = 1'b1;
        end else begin
            lat = d + 2; data = slv_mem[sel]; err = 1'b0;
        end
        if (err) begin
            if (exp_cnt < 255) exp_cnt++;
            exp_sel = sel;
        end
    endfunction

    task automatic do_access(input logic [AW-1:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] be, output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        @(negedge mclk);
        reg_cs = 1'b1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
        for (int n = 1; n <= 60; n++) begin
            @(negedge mclk);
            if (slv_cs != '0) begin
                if (o.cs_or == '0) begin
                    o.f_wr = slv_wr; o.f_addr = slv_addr; o.f_wdata = slv_wdata; o.f_be = slv_be;
                end
                o.cs_or = o.cs_or | slv_cs;
            end
            if (reg_ack) begin
                o.acks++;
                if (o.lat < 0) begin
                    o.lat = n; o.rdata = reg_rdata; o.err = reg_err;
                    reg_cs = 1'b0;
                end
            end else if (reg_rdata != 32'h0) begin
                o.leak = 1'b1;
            end
            if (o.lat > 0 && n >= o.lat + 3) break;
        end
        reg_cs = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge mclk);
        n_tests++;
        if ({reg_ack, reg_err, reg_rdata} !== 34'h0) begin
            n_fail++; $display("FAIL reset_resp: got ack=%b err=%b rdata=%h expected all 0", reg_ack, reg_err, reg_rdata);
        end
        n_tests++;
        if ({slv_cs, slv_wr, slv_addr, slv_wdata, slv_be} !== '0) begin
            n_fail++; $display("FAIL reset_slv: got cs=%b wr=%b addr=%h wdata=%h be=%b expected all 0", slv_cs, slv_wr, slv_addr, slv_wdata, slv_be);
        end
        n_tests++;
        if ({err_cnt, err_sel} !== '0) begin
            n_fail++; $display("FAIL reset_err: got cnt=%0d sel=%0d expected 0", err_cnt, err_sel);
        end
        s_reset = 1'b0;
        repeat (2) @(negedge mclk);
        $display("[TB] reset checked");
    endtask

    task automatic test_read_ch2();
        obs_t o;
        ack_delay[2] = 3; slv_mem[2] = 32'h1234_5678;
        do_access(11'h100, 1'b0, 32'h0, 4'hF, o);
        n_tests++;
        if (o.lat !== 5 || o.acks !== 1) begin
            n_fail++; $display("FAIL read_ch2_ack: got lat=%0d acks=%0d expected lat=5 acks=1", o.lat, o.acks);
        end
        n_tests++;
        if (o.rdata !== 32'h1234_5678 || o.err !== 1'b0) begin
            n_fail++; $display("FAIL read_ch2_data: got %h err=%b expected 12345678 err=0", o.rdata, o.err);
        end
        n_tests++;
        if (o.cs_or !== 4'b0100 || o.leak) begin
            n_fail++; $display("FAIL read_ch2_cs: got cs=%b leak=%b expected 0100 leak=0", o.cs_or, o.leak);
        end
        $display("[TB] read ch2 lat=%0d rdata=%h err=%b", o.lat, o.rdata, o.err);
    endtask

    task automatic test_write_ch0();
        obs_t o;
        ack_delay[0] = 0;
        do_access({4'd0, 7'h2A}, 1'b1, 32'hA5A5_A5A5, 4'b0011, o);
        n_tests++;
        if (o.f_wr !== 1'b1 || o.f_wdata !== 32'hA5A5_A5A5 || o.f_be !== 4'b0011 || o.f_addr !== 7'h2A) begin
            n_fail++; $display("FAIL write_ch0_fields: got wr=%b wdata=%h be=%b addr=%h expected 1 a5a5a5a5 0011 2a", o.f_wr, o.f_wdata, o.f_be, o.f_addr);
        end
        n_tests++;
        if (o.lat !== 2 || o.acks !== 1 || o.err !== 1'b0 || o.cs_or !== 4'b0001) begin
            n_fail++; $display("FAIL write_ch0_ack: got lat=%0d acks=%0d err=%b cs=%b expected 2 1 0 0001", o.lat, o.acks, o.err, o.cs_or);
        end
        $display("[TB] write ch0 lat=%0d", o.lat);
    endtask

    task automatic test_unmapped();
        obs_t o;
        do_access({4'd5, 7'h11}, 1'b0, 32'h0, 4'hF, o);
        n_tests++;
        if (o.lat !== 1 || o.rdata !== 32'h0 || o.err !== 1'b1 || o.cs_or !== 4'b0000) begin
            n_fail++; $display("FAIL unmapped_resp: got lat=%0d rdata=%h err=%b cs=%b expected 1 0 1 0000", o.lat, o.rdata, o.err, o.cs_or);
        end
        n_tests++;
        if (err_cnt !== 8'd1 || err_sel !== 4'd5) begin
            n_fail++; $display("FAIL unmapped_status: got cnt=%0d sel=%0d expected 1 5", err_cnt, err_sel);
        end
        $display("[TB] unmapped sel=5 lat=%0d err=%b", o.lat, o.err);
    endtask

    task automatic test_timeout();
        obs_t o;
        ack_delay[1] = -1;
        do_access({4'd1, 7'h05}, 1'b0, 32'h0, 4'hF, o);
        n_tests++;
        if (o.lat !== 17 || o.rdata !== 32'hDEAD_0001 || o.err !== 1'b1 || o.acks !== 1) begin
            n_fail++; $display("FAIL timeout_resp: got lat=%0d rdata=%h err=%b acks=%0d expected 17 dead0001 1 1", o.lat, o.rdata, o.err, o.acks);
        end
        n_tests++;
        if (err_cnt !== 8'd2 || err_sel !== 4'd1) begin
            n_fail++; $display("FAIL timeout_status: got cnt=%0d sel=%0d expected 2 1", err_cnt, err_sel);
        end
        $display("[TB] timeout ch1 lat=%0d rdata=%h", o.lat, o.rdata);
    endtask

    task automatic test_ack_timeout_tie();
        obs_t o;
        ack_delay[3] = TO - 1; slv_mem[3] = $urandom;
        do_access({4'd3, 7'h00}, 1'b0, 32'h0, 4'hF, o);
        n_tests++;
        if (o.lat !== 17 || o.rdata !== slv_mem[3] || o.err !== 1'b0) begin
            n_fail++; $display("FAIL tie_resp: got lat=%0d rdata=%h err=%b expected 17 %h 0", o.lat, o.rdata, o.err, slv_mem[3]);
        end
        n_tests++;
        if (err_cnt !== 8'd2) begin
            n_fail++; $display("FAIL tie_status: got cnt=%0d expected 2", err_cnt);
        end
        $display("[TB] ack/timeout tie lat=%0d err=%b", o.lat, o.err);
    endtask

    task automatic test_back_to_back();
        logic [12:0] seen;
        seen = '0;
        ack_delay[0] = 0;
        @(negedge mclk);
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = {4'd0, 7'h01};
        for (int n = 1; n <= 12; n++) begin
            @(negedge mclk);
            if (reg_ack) seen[n] = 1'b1;
        end
        reg_cs = 1'b0;
        repeat (4) @(negedge mclk);
        n_tests++;
        if (seen !== 13'h0444) begin
            n_fail++; $display("FAIL back_to_back: got ack cycles %b expected %b", seen, 13'h0444);
        end
        $display("[TB] back-to-back ack pattern %b", seen);
    endtask

    task automatic test_err_clr();
        obs_t o;
        err_clr = 1'b1;
        @(negedge mclk);
        err_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 8'd0 || err_sel !== 4'd0) begin
            n_fail++; $display("FAIL err_clr: got cnt=%0d sel=%0d expected 0 0", err_cnt, err_sel);
        end
        err_clr = 1'b1;
        do_access({4'd7, 7'h00}, 1'b0, 32'h0, 4'hF, o);
        err_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 8'd0 || err_sel !== 4'd0 || o.err !== 1'b1) begin
            n_fail++; $display("FAIL err_clr_wins: got cnt=%0d sel=%0d err=%b expected 0 0 1", err_cnt, err_sel, o.err);
        end
        exp_cnt = 0; exp_sel = 0;
        $display("[TB] err_clr checked");
    endtask

    task automatic test_random();
        obs_t o;
        int sel, d, lat;
        logic [31:0] data, wd;
        logic err, wr;
        logic [3:0] be;
        logic [6:0] lo;
        noise_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            sel = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(NS, 15));
            d   = int'($urandom_range(0, 21)) - 2;
            for (int i = 0; i < NS; i++) ack_delay[i] = int'($urandom_range(0, 5));
            if (sel < NS) begin
                ack_delay[sel] = d;
                slv_mem[sel] = $urandom;
            end
            wr = 1'($urandom); wd = $urandom; be = 4'($urandom); lo = 7'($urandom);
            model(sel, d, lat, data, err);
            do_access({4'(sel), lo}, wr, wd, be, o);
            n_tests++;
            if (o.lat !== lat || o.acks !== 1 || o.rdata !== data || o.err !== err || o.leak) begin
                n_fail++; $display("FAIL random_resp[%0d]: got lat=%0d acks=%0d rdata=%h err=%b leak=%b expected lat=%0d acks=1 rdata=%h err=%b leak=0",
                                   k, o.lat, o.acks, o.rdata, o.err, o.leak, lat, data, err);
            end
            n_tests++;
            if (sel < NS) begin
                if (o.cs_or !== (NS'(1) << sel) || o.f_wr !== wr || o.f_wdata !== wd || o.f_be !== be || o.f_addr !== lo) begin
                    n_fail++; $display("FAIL random_req[%0d]: got cs=%b wr=%b wdata=%h be=%b addr=%h expected sel=%0d wr=%b wdata=%h be=%b addr=%h",
                                       k, o.cs_or, o.f_wr, o.f_wdata, o.f_be, o.f_addr, sel, wr, wd, be, lo);
                end
            end else if (o.cs_or !== '0) begin
                n_fail++; $display("FAIL random_req[%0d]: got cs=%b expected 0000", k, o.cs_or);
            end
            n_tests++;
            if (err_cnt !== 8'(exp_cnt) || err_sel !== SW'(exp_sel)) begin
                n_fail++; $display("FAIL random_status[%0d]: got cnt=%0d sel=%0d expected %0d %0d", k, err_cnt, err_sel, exp_cnt, exp_sel);
            end
            $display("[TB] rnd %0d sel=%0d d=%0d lat=%0d rdata=%h err=%b", k, sel, d, o.lat, o.rdata, o.err);
        end
        noise_en = 1'b0;
    endtask

    task automatic test_err_saturation();
        obs_t o;
        int sel, lat, bad;
        logic [31:0] data;
        logic err;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(NS, 15));
            model(sel, 0, lat, data, err);
            do_access({4'(sel), 7'h00}, 1'b0, 32'h0, 4'hF, o);
            if (o.lat !== lat || o.err !== err || o.rdata !== data) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL saturation_resp: got %0d bad responses expected 0", bad);
        end
        n_tests++;
        if (err_cnt !== 8'd255 || err_sel !== SW'(exp_sel)) begin
            n_fail++; $display("FAIL saturation_status: got cnt=%0d sel=%0d expected 255 %0d", err_cnt, err_sel, exp_sel);
        end
        $display("[TB] 300 errors -> err_cnt=%0d err_sel=%0d", err_cnt, err_sel);
        err_clr = 1'b1;
        @(negedge mclk);
        err_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL saturation_clr: got cnt=%0d expected 0", err_cnt);
        end
        exp_cnt = 0; exp_sel = 0;
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        int acks;
        ack_delay[1] = -1;
        // Leave a non-zero error status behind so reset has something to clear.
        do_access({4'd9, 7'h00}, 1'b0, 32'h0, 4'hF, o);
        @(negedge mclk);
        reg_cs = 1'b1; reg_addr = {4'd1, 7'h33}; reg_wr = 1'b1; reg_wdata = 32'hCAFE_F00D;
        repeat (5) @(negedge mclk);
        n_tests++;
        if (slv_cs !== 4'b0010) begin
            n_fail++; $display("FAIL reset_mid_pre: got cs=%b expected 0010", slv_cs);
        end
        #2 s_reset = 1'b1;
        #1;
        n_tests++;
        if (slv_cs !== 4'b0000 || slv_wdata !== 32'h0 || slv_wr !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_cs: got cs=%b wr=%b wdata=%h expected 0000 0 0", slv_cs, slv_wr, slv_wdata);
        end
        reg_cs = 1'b0;
        @(negedge mclk);
        n_tests++;
        if (err_cnt !== 8'd0 || err_sel !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid_err: got cnt=%0d sel=%0d expected 0 0", err_cnt, err_sel);
        end
        s_reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge mclk);
            if (reg_ack) acks++;
        end
        n_tests++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL reset_mid_noack: got %0d acks expected 0", acks);
        end
        ack_delay[2] = 1; slv_mem[2] = 32'h0BAD_BEEF;
        do_access({4'd2, 7'h10}, 1'b0, 32'h0, 4'hF, o);
        n_tests++;
        if (o.lat !== 3 || o.rdata !== 32'h0BAD_BEEF || o.err !== 1'b0 || o.acks !== 1) begin
            n_fail++; $display("FAIL reset_mid_next: got lat=%0d rdata=%h err=%b acks=%0d expected 3 0badbeef 0 1", o.lat, o.rdata, o.err, o.acks);
        end
        $display("[TB] reset mid-access, post-reset acks=%0d next lat=%0d", acks, o.lat);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            ack_delay[i] = 0;
            slv_mem[i]   = 32'h1111_1111 * (i + 1);
            cs_cnt[i]    = 0;
        end
        repeat (3) @(negedge mclk);
        test_reset();
        test_read_ch2();
        test_write_ch0();
        test_unmapped();
        test_timeout();
        test_ack_timeout_tie();
        test_back_to_back();
        test_err_clr();
        test_random();
        test_err_saturation();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
